// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone sequencer and the board tops that
// drive it.
//   state_e    : sequencer states
//   MODE_*     : values of the 2-bit mode input
//   DEF_HALF   : reset value of the latched half period (A3 at 50 MHz)
//   NOTE_*_HALF: half-period-minus-one constants for a 50 MHz clock, ready to
//                drive the half_period input
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TONE_ON  = 2'd1,
    TONE_OFF = 2'd2
  } state_e;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_CONT  = 2'd1;
  localparam logic [1:0] MODE_BEEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  // Half period minus one: 50e6 / (2 * f) - 1.
  localparam int unsigned NOTE_A3_HALF = 113635;  // 220 Hz
  localparam int unsigned NOTE_A4_HALF = 56817;   // 440 Hz
  localparam int unsigned NOTE_C5_HALF = 47777;   // 523 Hz

  localparam int unsigned DEF_HALF = NOTE_A3_HALF;

endpackage

// File: rtl/buzzer_tone_seq_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debouncer and a
// registered one-cycle pulse on each accepted rising edge.
//   clk, rst_n : clock, synchronous active-low reset
//   button     : raw asynchronous button, active high
//   btn_pulse  : one-cycle pulse per accepted press (release is silent)
module btn_debounce #(
  parameter int unsigned DEB_CYC = 500000,
  parameter int unsigned DEB_W   = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_pulse
);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic             pulse_q, pulse_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    // The counter only runs while the synced level disagrees with the
    // accepted level; any agreement (a bounce back) restarts the count.
    if (sync2_q != db_q) begin
      if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = db_q & ~db_dly_q;
  end

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // edge-triggered block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let the synchroniser stages read each
      // other's previous values regardless of statement order.
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: rtl/buzzer_tone_seq.sv
// Button-started tone sequencer driving a piezo directly.
//   clk, rst_n  : clock, synchronous active-low reset
//   button      : raw push-button; each debounced press starts or stops
//   mode        : 0 off, 1 continuous, 2 repeating beep, 3 burst (latched at start)
//   half_period : tone half period minus one in clk cycles (re-latched per wrap)
//   buzzer_out  : registered square wave, low outside TONE_ON
//   active      : registered, high while not IDLE
//   btn_pulse   : one-cycle pulse per accepted press
//   burst_done  : one-cycle pulse when a burst ends by itself
module buzzer_tone_seq #(
  parameter int unsigned CNT_W        = 17,
  parameter int unsigned DEB_CYC      = 500000,
  parameter int unsigned DEB_W        = 19,
  parameter int unsigned BEEP_ON_CYC  = 10000000,
  parameter int unsigned BEEP_OFF_CYC = 10000000,
  parameter int unsigned GATE_W       = 24,
  parameter int unsigned BURST_N      = 3,
  parameter int unsigned DEF_HALF     = buzzer_pkg::DEF_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             button,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] half_period,
  output logic             buzzer_out,
  output logic             active,
  output logic             btn_pulse,
  output logic             burst_done
);

  import buzzer_pkg::*;

  localparam int unsigned BEEP_W = (BURST_N < 2) ? 1 : $clog2(BURST_N + 1);

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    hp_q, hp_d;
  logic [CNT_W-1:0]    tone_cnt_q, tone_cnt_d;
  logic                phase_q, phase_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [BEEP_W-1:0]   beep_q, beep_d;
  logic                buzzer_q, buzzer_d;
  logic                active_q, active_d;
  logic                burst_done_q, burst_done_d;
  logic [CNT_W-1:0]    hp_eff;
  logic                tone_wrap;

  btn_debounce #(
    .DEB_CYC (DEB_CYC),
    .DEB_W   (DEB_W)
  ) u_btn (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .btn_pulse (btn_pulse)
  );

  // A zero half period would toggle every cycle; clamp it to 1 (period 4).
  assign hp_eff    = (hp_q == '0) ? CNT_W'(1) : hp_q;
  assign tone_wrap = (tone_cnt_q == hp_eff);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    hp_d         = hp_q;
    tone_cnt_d   = '0;       // tone and gate counters idle at zero outside
    phase_d      = 1'b0;     // their state, so each TONE_ON entry starts low
    gate_d       = '0;
    beep_d       = beep_q;
    burst_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        beep_d = '0;
        if (btn_pulse && mode != MODE_OFF) begin
          mode_d  = mode;
          hp_d    = half_period;
          state_d = TONE_ON;
        end
      end

      TONE_ON: begin
        if (tone_wrap) begin
          // Pitch updates only at a wrap, so a half cycle is never cut short.
          hp_d    = half_period;
          phase_d = ~phase_q;
        end else begin
          tone_cnt_d = tone_cnt_q + 1'b1;
          phase_d    = phase_q;
        end
        if (mode_q != MODE_CONT) begin
          if (gate_q == GATE_W'(BEEP_ON_CYC - 1)) begin
            state_d = TONE_OFF;
          end else begin
            gate_d = gate_q + 1'b1;
          end
        end
      end

      TONE_OFF: begin
        if (gate_q == GATE_W'(BEEP_OFF_CYC - 1)) begin
          if (mode_q == MODE_BURST && beep_q == BEEP_W'(BURST_N - 1)) begin
            state_d      = IDLE;
            beep_d       = '0;
            burst_done_d = 1'b1;
          end else begin
            beep_d  = (mode_q == MODE_BURST) ? beep_q + 1'b1 : beep_q;
            state_d = TONE_ON;
          end
        end else begin
          gate_d = gate_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A press while running always stops, even against a same-cycle gate
    // expiry or burst end.
    if (btn_pulse && state_q != IDLE) begin
      state_d      = IDLE;
      tone_cnt_d   = '0;
      phase_d      = 1'b0;
      gate_d       = '0;
      beep_d       = '0;
      burst_done_d = 1'b0;
    end

    buzzer_d = phase_q & (state_q == TONE_ON);
    active_d = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_OFF;
      hp_q         <= CNT_W'(DEF_HALF);
      tone_cnt_q   <= '0;
      phase_q      <= 1'b0;
      gate_q       <= '0;
      beep_q       <= '0;
      buzzer_q     <= 1'b0;
      active_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      hp_q         <= hp_d;
      tone_cnt_q   <= tone_cnt_d;
      phase_q      <= phase_d;
      gate_q       <= gate_d;
      beep_q       <= beep_d;
      buzzer_q     <= buzzer_d;
      active_q     <= active_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign buzzer_out = buzzer_q;
  assign active     = active_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Self-checking bench for buzzer_tone_seq with short debounce/beep timings.
// Expected outputs come from closed-form timing rules: a press detected at
// cycle P gives outputs that follow the tone pattern from cycle P+2 on.
module tb_buzzer_tone_seq;

  localparam int ON      = 20;
  localparam int OFF     = 10;
  localparam int PER     = ON + OFF;
  localparam int BURST_N = 2;
  localparam int LAT     = 7;      // 2 sync + 4 debounce + 1 edge
  localparam int BIG     = 1 << 30;

  typedef enum int {K_CONT, K_BEEP, K_BURST, K_PITCH} kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        button = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [16:0] half_period = 17'd0;
  logic        buzzer_out, active, btn_pulse, burst_done;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_err = 0;
  bit    track = 1'b0;
  kind_e ref_kind = K_CONT;
  int    ref_p = BIG;
  int    ref_q = BIG;
  int    ref_h = 1;
  int    ref_h1 = 1;

  buzzer_tone_seq #(
    .CNT_W        (17),
    .DEB_CYC      (4),
    .DEB_W        (3),
    .BEEP_ON_CYC  (ON),
    .BEEP_OFF_CYC (OFF),
    .GATE_W       (5),
    .BURST_N      (BURST_N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .mode        (mode),
    .half_period (half_period),
    .buzzer_out  (buzzer_out),
    .active      (active),
    .btn_pulse   (btn_pulse),
    .burst_done  (burst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Expected outputs sampled after clock edge e.
  function automatic logic exp_buzz(input int e);
    int n, m;
    if (e < ref_p + 2 || e >= ref_q + 2) return 1'b0;
    n = e - ref_p - 2;
    case (ref_kind)
      K_CONT:  return ((n / (ref_h + 1)) % 2) == 1;
      K_PITCH: begin
        if (n < ref_h + 1) return 1'b0;
        return (((n - ref_h - 1) / (ref_h1 + 1)) % 2) == 0;
      end
      default: begin
        if (ref_kind == K_BURST && n >= BURST_N * PER) return 1'b0;
        m = n % PER;
        return (m < ON) && (((m / (ref_h + 1)) % 2) == 1);
      end
    endcase
  endfunction

  function automatic logic exp_active(input int e);
    if (e < ref_p + 2 || e > ref_q + 1) return 1'b0;
    if (ref_kind == K_BURST && e > ref_p + 1 + BURST_N * PER) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_done(input int e);
    return ref_kind == K_BURST && e == ref_p + 1 + BURST_N * PER &&
           ref_q > ref_p + BURST_N * PER;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (track) begin
      check("buzzer_out", buzzer_out, exp_buzz(cyc));
      check("active", active, exp_active(cyc));
      check("burst_done", burst_done, exp_done(cyc));
    end
  endtask

  task automatic quiet_ticks(input int n);
    repeat (n) begin
      tick();
      check("no_btn_pulse", btn_pulse, 1'b0);
    end
  endtask

  // Raise the button and wait (bounded) for the accepted press.
  task automatic press(output int p);
    int  c0;
    bit  seen;
    c0     = cyc;
    button = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (btn_pulse === 1'b1) seen = 1'b1;
    end
    p = cyc;
    check("press_seen", seen, 1'b1);
    check("press_latency", p - c0, LAT);
  endtask

  task automatic release_btn();
    button = 1'b0;
    quiet_ticks(10);
  endtask

  task automatic reset_refs(input kind_e k, input int h, input int h1);
    ref_kind = k;
    ref_h    = (h == 0) ? 1 : h;
    ref_h1   = h1;
    ref_p    = BIG;
    ref_q    = BIG;
  endtask

  initial begin
    int p, q, h, h1;
    bit seen;

    // Reset with the button toggling: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      button = ~button;
      @(negedge clk);
      check("rst_buzzer", buzzer_out, 1'b0);
      check("rst_active", active, 1'b0);
      check("rst_pulse", btn_pulse, 1'b0);
      check("rst_done", burst_done, 1'b0);
    end
    button = 1'b0;
    rst_n  = 1'b1;
    reset_refs(K_CONT, 1, 1);
    track = 1'b1;
    quiet_ticks(10);

    // Two-cycle glitch is filtered out.
    button = 1'b1;
    tick();
    tick();
    button = 1'b0;
    quiet_ticks(10);

    // Steady press with mode 0: pulse fires once, sequencer stays idle.
    mode = 2'd0;
    press(p);
    quiet_ticks(4);
    release_btn();

    // Continuous tone: spec pitch, then a random one.
    for (int r = 0; r < 2; r++) begin
      h = (r == 0) ? 3 : int'($urandom_range(0, 5));
      mode = 2'd1;
      half_period = 17'(h);
      reset_refs(K_CONT, h, 1);
      press(p);
      ref_p = p;
      quiet_ticks(1);
      release_btn();
      repeat ($urandom_range(20, 50)) tick();
      press(q);
      ref_q = q;
      quiet_ticks(1);
      release_btn();
    end

    // Burst that ends on its own.
    mode = 2'd3;
    h = int'($urandom_range(0, 3));
    half_period = 17'(h);
    reset_refs(K_BURST, h, 1);
    press(p);
    ref_p = p;
    quiet_ticks(1);
    release_btn();
    mode = 2'($urandom_range(0, 3));
    while (cyc < ref_p + BURST_N * PER + 10) tick();

    // Burst stopped by a press landing on the final off-gate expiry.
    mode = 2'd3;
    h = int'($urandom_range(0, 3));
    half_period = 17'(h);
    reset_refs(K_BURST, h, 1);
    press(p);
    ref_p = p;
    quiet_ticks(1);
    release_btn();
    while (cyc < ref_p + BURST_N * PER - LAT) tick();
    press(q);
    check("coincident_press_cycle", q - ref_p, BURST_N * PER);
    ref_q = q;
    quiet_ticks(1);
    release_btn();

    // Pitch change inside the first half cycle: spec values, then random.
    for (int r = 0; r < 2; r++) begin
      h  = (r == 0) ? 3 : int'($urandom_range(1, 4));
      h1 = (r == 0) ? 7 : int'($urandom_range(5, 8));
      mode = 2'd1;
      half_period = 17'(h);
      reset_refs(K_PITCH, h, h1);
      press(p);
      ref_p = p;
      quiet_ticks(2);
      half_period = 17'(h1);
      release_btn();
      repeat (40) tick();
      press(q);
      ref_q = q;
      quiet_ticks(1);
      release_btn();
    end

    // Repeating beep; mode input changes mid-run are ignored.
    mode = 2'd2;
    h = int'($urandom_range(0, 2));
    half_period = 17'(h);
    reset_refs(K_BEEP, h, 1);
    press(p);
    ref_p = p;
    quiet_ticks(1);
    release_btn();
    mode = 2'($urandom_range(0, 3));
    repeat (70) tick();

    // Reset while the tone is high.
    track = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (buzzer_out === 1'b1) seen = 1'b1;
    end
    check("beep_high_before_reset", seen, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midbeep_rst_buzzer", buzzer_out, 1'b0);
    check("midbeep_rst_active", active, 1'b0);
    check("midbeep_rst_pulse", btn_pulse, 1'b0);
    check("midbeep_rst_done", burst_done, 1'b0);
    rst_n = 1'b1;
    reset_refs(K_CONT, 1, 1);
    track = 1'b1;
    quiet_ticks(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_seq.md
Name: buzzer_tone_seq

Overview:
- Parametrised successor to the single-tone button buzzer.
- Debounces a raw push-button and uses each debounced press to start or stop a tone.
- Tone pitch is runtime-programmable through a half-period input.
- Three sound modes: continuous, repeating beep (on/off gated), and a fixed-count beep burst that auto-stops; drives the board piezo pin directly.

Parameters:
- CNT_W, 17, width of tone half-period counter and half_period input
- DEB_CYC, 500000, consecutive stable cycles required to accept a button level (10 ms at 50 MHz)
- DEB_W, 19, width of debounce counter (must hold DEB_CYC)
- BEEP_ON_CYC, 10000000, cycles tone is audible per beep (200 ms)
- BEEP_OFF_CYC, 10000000, silent cycles between beeps
- GATE_W, 24, width of beep gate counter (must hold max of ON/OFF)
- BURST_N, 3, beeps emitted in burst mode before auto-stop
- DEF_HALF, 113635, reset value of latched half period (220 Hz at 50 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- button  in  1  raw asynchronous push-button, active high
- mode  in  2  0=off, 1=continuous, 2=repeating beep, 3=burst
- half_period  in  CNT_W  tone half period minus one, in clk cycles
- buzzer_out  out  1  square wave to piezo
- active  out  1  high while sequencer is not IDLE
- btn_pulse  out  1  one-cycle pulse per accepted press
- burst_done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset: rst_n sampled on clk edge only; all outputs 0; FSM=IDLE; latched half period=DEF_HALF; latched mode=0; all counters 0; sync flops and debounced level 0.
- Input conditioning: button passes a 2-FF synchroniser. Debounce counter clears whenever the synced level equals btn_db. Otherwise it increments; when it reaches DEB_CYC-1, btn_db takes the synced level and the counter clears. Bounce shorter than DEB_CYC never changes btn_db.
- Press event: btn_pulse=1 for exactly one cycle on a btn_db rising edge. The release edge produces nothing.
- FSM states: IDLE, TONE_ON, TONE_OFF.
  - IDLE + btn_pulse with mode!=0: latch mode and half_period; clear gate, tone and beep counters; go to TONE_ON.
  - IDLE + btn_pulse with mode=0: stay IDLE; btn_pulse still fires.
  - Any non-IDLE state + btn_pulse: go to IDLE next cycle; counters cleared.
  - TONE_ON, latched mode 1: stay indefinitely.
  - TONE_ON, modes 2/3: after BEEP_ON_CYC cycles in state, go to TONE_OFF.
  - TONE_OFF, mode 2: after BEEP_OFF_CYC cycles, go to TONE_ON.
  - TONE_OFF, mode 3: increment beep count. If count reaches BURST_N, go to IDLE and pulse burst_done for one cycle (on the TONE_OFF->IDLE transition). Otherwise go to TONE_ON after BEEP_OFF_CYC.
- Mode/pitch changes while active:
  - mode is ignored after latching; it takes effect on the next start.
  - half_period is re-latched at every tone wrap, so pitch changes land glitch-free on a half-cycle boundary.
- Tone generator (runs only in TONE_ON):
  - counter counts 0..hp_lat; on reaching hp_lat it wraps to 0 and the phase toggles.
  - half_period=0 is treated as 1, giving a minimum period of 4 clk.
  - On entering TONE_ON, phase=0 and counter=0, so every beep starts low.
- Outputs:
  - buzzer_out is registered = phase AND (state==TONE_ON): 1-cycle latency from phase, and low in IDLE/TONE_OFF.
  - active is registered = (state!=IDLE).
- Simultaneous events:
  - btn_pulse in the same cycle as a gate expiry or burst end: the press wins and the FSM goes to IDLE. burst_done is not pulsed.
  - rst_n low overrides everything, mid-beep included.

Decomposition:
- Shared package buzzer_pkg holds:
  - state enum (IDLE, TONE_ON, TONE_OFF)
  - mode constants (MODE_OFF, MODE_CONT, MODE_BEEP, MODE_BURST)
  - DEF_HALF and the 50 MHz note half-period constants (e.g. A3=113635, A4=56817, C5=47777), for board tops to drive half_period
- One natural sub-module, btn_debounce (synchroniser + debounce + rising-edge pulse), parametrised by DEB_CYC/DEB_W; the team will reuse it for other board buttons.
- Tone divider and FSM stay in the top.

Test Plan (DEB_CYC=4, BEEP_ON_CYC=20, BEEP_OFF_CYC=10, BURST_N=2):
- Reset then idle: hold rst_n=0 for 3 cycles with button toggling -> buzzer_out=active=btn_pulse=burst_done=0; after release, no activity with button=0.
- Debounce: 2-cycle glitch on button -> no btn_pulse. Steady high for 10 cycles -> exactly one btn_pulse, 2 (sync) + 4 (debounce) + 1 (edge) cycles after the rise.
- Continuous tone: mode=1, half_period=3, press -> active=1; buzzer_out is a period-8 square wave starting low. Second press -> buzzer_out=0 and active=0 within 2 cycles.
- Beep mode: mode=2, half_period=1 -> buzzer_out toggles every 2 cycles for 20 cycles, then is low for 10, repeating; changing mode mid-run has no effect.
- Burst: mode=3 press -> exactly 2 beeps, then burst_done is a single 1-cycle pulse and active=0. A press coincident with the final TONE_OFF expiry -> no burst_done.
- Pitch change mid-tone: half_period changes 3->7 at a mid-half-cycle point -> the current half-cycle completes at 4 cycles and the next half-cycles are 8 cycles, with no short pulse. Reset asserted mid-beep -> all outputs 0 on the next cycle.
